aes_keysched_ctrl: RTL

AES_KEYSCHED_CTRL -- requirements
Module: aes_keysched_ctrl

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_keysched_ctrl_if.sv | 27 ++
 rtl/aes_rk_buf.sv | 47 ++++
 rtl/aes_keysched_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and defaults for the AES key-schedule controller.
package aes_pkg;

  typedef logic [127:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam int NROUNDS_DEF = 10;
  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/aes_keysched_ctrl_if.sv
// Link between the key-schedule controller and the newkey unit.
//
// Handshake: the controller raises nk_start with nk_in/nk_key stable and holds
// it high until it has accepted a result. The newkey unit answers by raising
// nk_finish with nk_newkey valid; the controller takes the result on the first
// rising edge where it is waiting and nk_finish=1, then drops nk_start for one
// cycle. nk_finish seen in the very first cycle of nk_start is treated as stale
// from a previous round and ignored.
interface aes_keysched_ctrl_if;
  import aes_pkg::*;

  logic nk_start;
  key_t nk_in;
  key_t nk_key;
  logic nk_finish;
  key_t nk_newkey;

  modport master (
    output nk_start, nk_in, nk_key,
    input  nk_finish, nk_newkey
  );

  modport slave (
    input  nk_start, nk_in, nk_key,
    output nk_finish, nk_newkey
  );
endinterface

// File: rtl/aes_rk_buf.sv
// Round-key storage: one synchronous write port, one combinational read port.
// Reads past the last entry return zero.
module aes_rk_buf
  import aes_pkg::*;
#(
  parameter int DEPTH = NROUNDS_DEF + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] wr_idx,
  input  key_t       wr_data,
  input  logic [3:0] rd_idx,
  output key_t       rd_data
);

  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

  key_t mem_q [DEPTH];
  key_t mem_d [DEPTH];

  // Next contents: a single entry replaced on a write.
  always_comb begin
    mem_d = mem_q;
    if (we && (wr_idx <= LAST_IDX)) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  // Storage register; reset wipes every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Combinational read with zero for out-of-range indices.
  always_comb begin
    rd_data = '0;
    if (rd_idx <= LAST_IDX) begin
      rd_data = mem_q[rd_idx];
    end
  end

endmodule

// File: rtl/aes_keysched_ctrl.sv
// Sequences the external newkey unit through NROUNDS rounds, storing the
// cipher key and every round key in a buffer readable at any time.
module aes_keysched_ctrl
  import aes_pkg::*;
#(
  parameter int NROUNDS = NROUNDS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  key_t                 key_in,
  output logic                 busy,
  output logic                 done,
  output logic                 keys_valid,
  output logic                 error,
  input  logic [3:0]           rd_idx,
  output key_t                 rd_key,
  output state_t               state_dbg,
  aes_keysched_ctrl_if.master  nk
);

  localparam int         TW         = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [TW-1:0] tmo_q, tmo_d;
  key_t          nk_key_q, nk_key_d;
  // Always holds the most recently stored key, i.e. buf[round-1] while a
  // round is being computed, so no second buffer read port is needed.
  key_t          nk_in_q, nk_in_d;
  logic          error_q, error_d;
  logic          keys_valid_q, keys_valid_d;
  logic          done_q, done_d;

  logic          buf_we;
  logic [3:0]    buf_wr_idx;
  key_t          buf_wr_data;

  // Next-state and datapath control for the round sequencer.
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    tmo_d        = tmo_q;
    nk_key_d     = nk_key_q;
    nk_in_d      = nk_in_q;
    error_d      = error_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    buf_we       = 1'b0;
    buf_wr_idx   = round_q;
    buf_wr_data  = nk.nk_newkey;

    unique case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          nk_key_d     = key_in;
          nk_in_d      = key_in;
          buf_we       = 1'b1;
          buf_wr_idx   = '0;
          buf_wr_data  = key_in;
          round_d      = 4'd1;
          tmo_d        = '0;
          error_d      = 1'b0;
          keys_valid_d = 1'b0;
          state_d      = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // nk_finish deliberately ignored here: it may be left over from the
        // previous round.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (nk.nk_finish) begin
          buf_we  = 1'b1;
          nk_in_d = nk.nk_newkey;
          state_d = ST_GAP;
        end else if (tmo_q == TMO_LAST) begin
          error_d      = 1'b1;
          keys_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (round_q == LAST_ROUND) begin
          done_d       = 1'b1;
          keys_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          round_d = round_q + 4'd1;
          tmo_d   = '0;
          state_d = ST_LAUNCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      round_q      <= '0;
      tmo_q        <= '0;
      nk_key_q     <= '0;
      nk_in_q      <= '0;
      error_q      <= 1'b0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      tmo_q        <= tmo_d;
      nk_key_q     <= nk_key_d;
      nk_in_q      <= nk_in_d;
      error_q      <= error_d;
      keys_valid_q <= keys_valid_d;
      done_q       <= done_d;
    end
  end

  aes_rk_buf #(
    .DEPTH (NROUNDS + 1)
  ) u_rk_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (buf_we),
    .wr_idx  (buf_wr_idx),
    .wr_data (buf_wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_key)
  );

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign keys_valid  = keys_valid_q;
  assign error       = error_q;
  assign state_dbg   = state_q;
  assign nk.nk_start = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign nk.nk_in    = nk_in_q;
  assign nk.nk_key   = nk_key_q;

endmodule
